// File: rtl/egk_bin_serializer_if.sv
// rtl/egk_bin_serializer_if.sv - codeword input and bin output handshake bundle
interface egk_bin_serializer_if #(
    parameter int MAX_BITS = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [MAX_BITS-1:0] in_code;
    logic [MAX_BITS-1:0] in_len;
    logic                bin_valid;
    logic                bin_ready;
    logic                bin_out;
    logic                bin_last;

    modport master (
        output in_valid, in_code, in_len, bin_ready,
        input  in_ready, bin_valid, bin_out, bin_last
    );

    modport slave (
        input  in_valid, in_code, in_len, bin_ready,
        output in_ready, bin_valid, bin_out, bin_last
    );
endinterface

// File: rtl/egk_bin_serializer.sv
// rtl/egk_bin_serializer.sv - Exp-Golomb codeword FIFO and MSB-first bin serializer
// EGK_BIN_STATS_EN adds bin_total/cw_total consumer-side counters.
module egk_bin_serializer #(
    parameter int MAX_BITS = 16,
    parameter int DEPTH    = 4,
    parameter int LEN_BITS = $clog2(MAX_BITS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    egk_bin_serializer_if.slave bus,
    output logic [LEN_BITS-1:0] fifo_count,
    output logic                len_err
`ifdef EGK_BIN_STATS_EN
    ,
    output logic [31:0]         bin_total,
    output logic [31:0]         cw_total
`endif
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int IDX_BITS = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [LEN_BITS-1:0] DEPTH_L = LEN_BITS'(DEPTH);
    localparam logic [MAX_BITS-1:0] MAX_L   = MAX_BITS'(MAX_BITS);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [MAX_BITS-1:0] code_mem [DEPTH];
    logic [LEN_BITS-1:0] len_mem  [DEPTH];

    state_t              state_q, state_d;
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_BITS-1:0] count_q, count_d;
    logic [MAX_BITS-1:0] cur_code_q, cur_code_d;
    logic [IDX_BITS-1:0] cur_idx_q, cur_idx_d;
    logic                bin_valid_q, bin_valid_d;
    logic                bin_out_q, bin_out_d;
    logic                bin_last_q, bin_last_d;
    logic                len_err_q, len_err_d;
`ifdef EGK_BIN_STATS_EN
    logic [31:0]         bin_total_q, bin_total_d;
    logic [31:0]         cw_total_q, cw_total_d;
`endif

    logic                in_ready;
    logic                accept;
    logic                over_len;
    logic [LEN_BITS-1:0] in_len_c;
    logic                push;
    logic                fifo_empty;
    logic [MAX_BITS-1:0] head_code;
    logic [LEN_BITS-1:0] head_len;
    logic                head_avail;
    logic                take;
    logic                load;
    logic                pop;
    logic                store;

    always_comb begin
        in_ready   = (count_q < DEPTH_L);
        accept     = bus.in_valid && in_ready;
        over_len   = (bus.in_len > MAX_L);
        in_len_c   = over_len ? LEN_BITS'(MAX_BITS) : LEN_BITS'(bus.in_len);
        push       = accept && (bus.in_len != '0);
        fifo_empty = (count_q == '0);
        // With the FIFO empty the incoming codeword bypasses storage so bins start next cycle.
        head_code  = fifo_empty ? bus.in_code : code_mem[rd_ptr_q];
        head_len   = fifo_empty ? in_len_c : len_mem[rd_ptr_q];
        head_avail = !fifo_empty || push;
        take       = (state_q == S_SEND) && bus.bin_ready;
        load       = ((state_q == S_IDLE) || (take && (cur_idx_q == '0))) && head_avail;
        pop        = load && !fifo_empty;
        store      = push && !(load && fifo_empty);

        state_d    = state_q;
        cur_code_d = cur_code_q;
        cur_idx_d  = cur_idx_q;
        if (load) begin
            state_d    = S_SEND;
            cur_code_d = head_code;
            cur_idx_d  = IDX_BITS'(head_len - LEN_BITS'(1));
        end else if (take && (cur_idx_q != '0)) begin
            cur_idx_d = cur_idx_q - IDX_BITS'(1);
        end else if (take) begin
            state_d = S_IDLE;
        end

        bin_valid_d = (state_d == S_SEND);
        bin_out_d   = bin_valid_d && cur_code_d[cur_idx_d];
        bin_last_d  = bin_valid_d && (cur_idx_d == '0);

        wr_ptr_d = store ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
        case ({store, pop})
            2'b10:   count_d = count_q + LEN_BITS'(1);
            2'b01:   count_d = count_q - LEN_BITS'(1);
            default: count_d = count_q;
        endcase

        len_err_d = len_err_q || (accept && over_len);
`ifdef EGK_BIN_STATS_EN
        bin_total_d = bin_total_q + {31'b0, take};
        cw_total_d  = cw_total_q + {31'b0, take && bin_last_q};
`endif
    end

    always_ff @(posedge clk) begin
        if (store) begin
            code_mem[wr_ptr_q] <= bus.in_code;
            len_mem[wr_ptr_q]  <= in_len_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_code_q  <= '0;
            cur_idx_q   <= '0;
            bin_valid_q <= 1'b0;
            bin_out_q   <= 1'b0;
            bin_last_q  <= 1'b0;
            len_err_q   <= 1'b0;
`ifdef EGK_BIN_STATS_EN
            bin_total_q <= '0;
            cw_total_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cur_code_q  <= cur_code_d;
            cur_idx_q   <= cur_idx_d;
            bin_valid_q <= bin_valid_d;
            bin_out_q   <= bin_out_d;
            bin_last_q  <= bin_last_d;
            len_err_q   <= len_err_d;
`ifdef EGK_BIN_STATS_EN
            bin_total_q <= bin_total_d;
            cw_total_q  <= cw_total_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.bin_valid = bin_valid_q;
    assign bus.bin_out   = bin_out_q;
    assign bus.bin_last  = bin_last_q;
    assign fifo_count    = count_q;
    assign len_err       = len_err_q;
`ifdef EGK_BIN_STATS_EN
    assign bin_total     = bin_total_q;
    assign cw_total      = cw_total_q;
`endif

endmodule

// File: tb/tb_egk_bin_serializer.sv
// tb/tb_egk_bin_serializer.sv - directed self-checking bench for egk_bin_serializer
module tb_egk_bin_serializer;

    logic       clk;
    logic       rst;
    logic [4:0] fifo_count;
    logic       len_err;
`ifdef EGK_BIN_STATS_EN
    logic [31:0] bin_total;
    logic [31:0] cw_total;
`endif

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    logic got_bit[$];
    logic got_last[$];
    int   got_cyc[$];
    logic exp_bit[$];
    logic exp_last[$];

    egk_bin_serializer_if #(.MAX_BITS(16)) ifc ();

    egk_bin_serializer #(
        .MAX_BITS(16),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc),
        .fifo_count(fifo_count),
        .len_err(len_err)
`ifdef EGK_BIN_STATS_EN
        ,
        .bin_total(bin_total),
        .cw_total(cw_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && ifc.bin_valid && ifc.bin_ready) begin
            got_bit.push_back(ifc.bin_out);
            got_last.push_back(ifc.bin_last);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cw(input logic [15:0] code, input logic [15:0] len);
        ifc.in_valid = 1'b1;
        ifc.in_code  = code;
        ifc.in_len   = len;
        step();
        ifc.in_valid = 1'b0;
    endtask

    task automatic clear_q();
        got_bit.delete();
        got_last.delete();
        got_cyc.delete();
        exp_bit.delete();
        exp_last.delete();
    endtask

    task automatic add_cw(input logic [15:0] code, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            exp_bit.push_back(code[i]);
            exp_last.push_back(i == 0);
        end
    endtask

    task automatic wait_bins(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got_bit.size() < n && k < budget) begin
            step();
            k++;
        end
        check_eq({tag, "_arrive"}, 32'(got_bit.size() >= n), 32'd1);
    endtask

    task automatic check_bins(input string tag);
        int n;
        check_eq({tag, "_count"}, 32'(got_bit.size()), 32'(exp_bit.size()));
        n = (got_bit.size() < exp_bit.size()) ? got_bit.size() : exp_bit.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_bit%0d", tag, i), 32'(got_bit[i]), 32'(exp_bit[i]));
            check_eq($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_code   = '0;
        ifc.in_len    = '0;
        ifc.bin_ready = 1'b0;
        step();
        check_eq("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        check_eq("rst_bin_valid", 32'(ifc.bin_valid), 32'd0);
        check_eq("rst_bin_out", 32'(ifc.bin_out), 32'd0);
        check_eq("rst_bin_last", 32'(ifc.bin_last), 32'd0);
        check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
        check_eq("rst_len_err", 32'(len_err), 32'd0);
        rst = 1'b0;
        step();

        // Single codeword EG0(3) = 11000
        clear_q();
        ifc.bin_ready = 1'b1;
        add_cw(16'h0018, 5);
        drive_cw(16'h0018, 16'd5);
        check_eq("t1_latency_valid", 32'(ifc.bin_valid), 32'd1);
        check_eq("t1_latency_bit", 32'(ifc.bin_out), 32'd1);
        wait_bins("t1", 5, 20);
        repeat (3) step();
        check_eq("t1_idle_valid", 32'(ifc.bin_valid), 32'd0);
        check_bins("t1");
        if (got_cyc.size() == 5)
            check_eq("t1_contig", 32'(got_cyc[4] - got_cyc[0]), 32'd4);

        // Back-to-back codewords, no bubble
        clear_q();
        add_cw(16'h0018, 5);
        add_cw(16'h0000, 1);
        drive_cw(16'h0018, 16'd5);
        drive_cw(16'h0000, 16'd1);
        wait_bins("t2", 6, 20);
        repeat (3) step();
        check_bins("t2");
        if (got_cyc.size() == 6)
            check_eq("t2_contig", 32'(got_cyc[5] - got_cyc[0]), 32'd5);

        // Fill with consumer stalled, then drain
        clear_q();
        ifc.bin_ready = 1'b0;
        add_cw(16'h0005, 3);
        add_cw(16'h0003, 3);
        add_cw(16'h0006, 3);
        add_cw(16'h0001, 3);
        add_cw(16'h0004, 3);
        drive_cw(16'h0005, 16'd3);
        drive_cw(16'h0003, 16'd3);
        drive_cw(16'h0006, 16'd3);
        drive_cw(16'h0001, 16'd3);
        drive_cw(16'h0004, 16'd3);
        check_eq("t3_full_count", 32'(fifo_count), 32'd4);
        check_eq("t3_full_in_ready", 32'(ifc.in_ready), 32'd0);
        repeat (3) step();
        check_eq("t3_stall_valid", 32'(ifc.bin_valid), 32'd1);
        check_eq("t3_stall_bit", 32'(ifc.bin_out), 32'd1);
        check_eq("t3_stall_last", 32'(ifc.bin_last), 32'd0);
        ifc.bin_ready = 1'b1;
        check_eq("t3_rdy_c1", 32'(ifc.in_ready), 32'd0);
        step();
        check_eq("t3_rdy_c2", 32'(ifc.in_ready), 32'd0);
        step();
        check_eq("t3_rdy_c3", 32'(ifc.in_ready), 32'd0);
        step();
        check_eq("t3_rdy_c4", 32'(ifc.in_ready), 32'd1);
        check_eq("t3_count_c4", 32'(fifo_count), 32'd3);
        wait_bins("t3", 15, 40);
        repeat (3) step();
        check_bins("t3");
        check_eq("t3_drained_count", 32'(fifo_count), 32'd0);

        // Zero length is swallowed
        clear_q();
        drive_cw(16'h001F, 16'd0);
        repeat (4) step();
        check_eq("t4_zero_bins", 32'(got_bit.size()), 32'd0);
        check_eq("t4_zero_valid", 32'(ifc.bin_valid), 32'd0);
        check_eq("t4_zero_count", 32'(fifo_count), 32'd0);
        check_eq("t4_zero_len_err", 32'(len_err), 32'd0);

        // Oversized length clamps to 16 and flags len_err
        clear_q();
        add_cw(16'hA5C3, 16);
        drive_cw(16'hA5C3, 16'd20);
        check_eq("t4_len_err_set", 32'(len_err), 32'd1);
        wait_bins("t4", 16, 40);
        repeat (4) step();
        check_bins("t4");
        check_eq("t4_len_err_sticky", 32'(len_err), 32'd1);

        // Reset in the middle of a codeword
        clear_q();
        drive_cw(16'h0018, 16'd5);
        step();
        #6;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", 32'(ifc.bin_valid), 32'd0);
        check_eq("t5_rst_count", 32'(fifo_count), 32'd0);
        check_eq("t5_rst_in_ready", 32'(ifc.in_ready), 32'd1);
        check_eq("t5_rst_len_err", 32'(len_err), 32'd0);
        check_eq("t5_bins_before_rst", 32'(got_bit.size()), 32'd2);
        step();
        rst = 1'b0;
        step();
        clear_q();
        add_cw(16'h0005, 3);
        drive_cw(16'h0005, 16'd3);
        wait_bins("t5", 3, 20);
        repeat (3) step();
        check_bins("t5");

`ifdef EGK_BIN_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_eq("t6_rst_bin_total", bin_total, 32'd0);
        clear_q();
        ifc.bin_ready = 1'b0;
        add_cw(16'h0018, 5);
        add_cw(16'h0000, 1);
        add_cw(16'h0005, 3);
        drive_cw(16'h0018, 16'd5);
        drive_cw(16'h0000, 16'd1);
        drive_cw(16'h0005, 16'd3);
        for (int k = 0; k < 300 && got_bit.size() < 9; k++) begin
            ifc.bin_ready = 1'($urandom_range(0, 1));
            step();
        end
        ifc.bin_ready = 1'b1;
        repeat (3) step();
        check_bins("t6");
        check_eq("t6_bin_total", bin_total, 32'd9);
        check_eq("t6_cw_total", cw_total, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
